matrix_feeder: RTL and testbench
================================

MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter DRAIN, default 4, zero-fill cycles after the data feed.
REQ-003 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have rx_data  input  DATAWIDTH  byte from UART receiver.
REQ-006 SHALL have rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have go  input  1  request to stream loaded matrices to the systolic array.
REQ-008 SHALL have A0, A1, A2  output  DATAWIDTH each  skewed row streams of A (registered).
REQ-009 SHALL have B0, B1, B2  output  DATAWIDTH each  skewed column streams of B (registered).
REQ-010 SHALL have feed_valid  output  1  high while A*/B* carry matrix data.
REQ-011 SHALL have loaded  output  1  high while all 18 elements are held and feed has not started.
REQ-012 SHALL have busy  output  1  high during FEED and DRAIN.
REQ-013 SHALL have done  output  1  one-cycle pulse at end of DRAIN.
REQ-014 SHALL have overrun  output  1  sticky: rx_valid arrived while not in LOAD.

Function
REQ-015 SHALL implement states LOAD, FULL, FEED, DRAIN, DONE.
REQ-016 LOAD: each rx_valid writes rx_data to index cnt (0..17), then cnt++; idx 0..8 -> A[r][c] row-major, 9..17 -> B[r][c] row-major.
REQ-017 LOAD -> FULL on the edge that accepts byte 17; loaded=1 from the next cycle.
REQ-018 go SHALL be ignored in LOAD; no partial feed.
REQ-019 FULL -> FEED on the edge sampling go=1; feed cycles t=0..4 occupy the next five cycles.
REQ-020 In feed cycle t: Ai = A[i][t-i] if 0<=t-i<=2, else 0; Bj = B[t-j][j] if 0<=t-j<=2, else 0.
REQ-021 feed_valid=1 and busy=1 in all five feed cycles; loaded=0 from the first feed cycle.
REQ-022 FEED -> DRAIN after t=4; DRAIN lasts DRAIN cycles with all A*/B*=0, feed_valid=0, busy=1.
REQ-023 DRAIN -> DONE; done=1, busy=0 for exactly one cycle; then LOAD with cnt=0.
REQ-024 Latency: go sampled at edge k -> t=0 in cycle k+1, done in cycle k+6+DRAIN.
REQ-025 rx_valid in FULL, FEED, DRAIN or DONE SHALL be dropped (storage unchanged) and set overrun.
REQ-026 rx_valid and go together in FULL: go wins, byte dropped, overrun set.
REQ-027 go outside FULL SHALL have no effect; go held high SHALL not restart a feed until the next FULL.
REQ-028 Stored matrices SHALL persist after DONE until overwritten in LOAD.
REQ-029 A*/B* SHALL be 0 in every cycle outside FEED.

Reset
REQ-030 rst=1 at an edge SHALL force LOAD, cnt=0, A*/B*=0, feed_valid=0, loaded=0, busy=0, done=0, overrun=0, from any state including mid-feed.
REQ-031 Matrix storage need not be cleared on reset; it SHALL never be output before a complete reload.

Verification
REQ-032 Load A=1..9 row-major, B=identity, go -> A0/A1/A2 over t=0..4: (1,0,0),(2,4,0),(3,5,7),(0,6,8),(0,0,9); B0=(1,0,0,0,0), B1=(0,0,1,0,0), B2=(0,0,0,0,1); feed_valid 5 cycles, then 4 zero cycles, done at k+10.
REQ-033 Send 17 bytes, pulse go -> no feed, loaded=0; send byte 18 -> loaded=1 next cycle; go -> feed starts.
REQ-034 In FULL, send extra byte 0xFF together with go -> overrun=1, feed data identical to REQ-032.
REQ-035 Assert rst at feed cycle t=2 -> next cycle all outputs 0, state LOAD; reload 18 bytes and feed correctly.
REQ-036 After done, send 18 new bytes and go -> second feed uses new values, overrun remains 0.
REQ-037 Hold go high continuously through a full run -> exactly one feed per completed load.

Source files
------------

// File: rtl/matrix_feeder.sv
// Loads two 3x3 matrices byte-by-byte from a UART stream, then streams them skewed into a 3x3 systolic array.
// Latency: go sampled at edge k gives feed t=0 in cycle k+1, last data t=4 in cycle k+5, done pulse in cycle k+6+DRAIN.
// No backpressure: bytes arriving outside LOAD are dropped and flagged via the sticky overrun output.
module matrix_feeder #(
    parameter int DATAWIDTH = 8,
    parameter int DRAIN     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] rx_data,
    input  logic                 rx_valid,
    input  logic                 go,
    output logic [DATAWIDTH-1:0] A0,
    output logic [DATAWIDTH-1:0] A1,
    output logic [DATAWIDTH-1:0] A2,
    output logic [DATAWIDTH-1:0] B0,
    output logic [DATAWIDTH-1:0] B1,
    output logic [DATAWIDTH-1:0] B2,
    output logic                 feed_valid,
    output logic                 loaded,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_FULL  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;
    logic [4:0]  r_cnt,  w_cnt_nxt;
    logic [2:0]  r_t,    w_t_nxt;
    logic [15:0] r_dcnt, w_dcnt_nxt;

    // Storage: indices 0..8 hold A row-major, 9..17 hold B row-major.
    logic [DATAWIDTH-1:0] r_mem [0:17];

    logic [DATAWIDTH-1:0] w_a_nxt [0:2];
    logic [DATAWIDTH-1:0] w_b_nxt [0:2];
    logic [DATAWIDTH-1:0] r_a     [0:2];
    logic [DATAWIDTH-1:0] r_b     [0:2];
    logic w_fv_nxt, w_loaded_nxt, w_busy_nxt, w_done_nxt;
    logic r_fv, r_loaded, r_busy, r_done, r_overrun;
    logic w_accept;

    assign w_accept = rx_valid && (r_state == S_LOAD);

    // State register: FSM state plus load index, feed step and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_t     <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_t     <= w_t_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Next-state logic: go only matters in FULL, so a held go cannot restart a feed early.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_t_nxt     = r_t;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            S_LOAD: begin
                if (rx_valid) begin
                    if (r_cnt == 5'd17) begin
                        w_state_nxt = S_FULL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
            S_FULL: begin
                if (go) begin
                    w_state_nxt = S_FEED;
                    w_t_nxt     = '0;
                end
            end
            S_FEED: begin
                if (r_t == 3'd4) begin
                    w_t_nxt = '0;
                    if (DRAIN > 0) begin
                        w_state_nxt = S_DRAIN;
                        w_dcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_t_nxt = r_t + 3'd1;
                end
            end
            S_DRAIN: begin
                if (r_dcnt == 16'(DRAIN - 1)) begin
                    w_state_nxt = S_DONE;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + 16'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: computed from the next state so the registered outputs line up with the state they describe.
    always_comb begin
        int d;
        d = 0;
        for (int i = 0; i < 3; i++) begin
            w_a_nxt[i] = '0;
            w_b_nxt[i] = '0;
            d = int'(w_t_nxt) - i;
            if ((w_state_nxt == S_FEED) && (d >= 0) && (d <= 2)) begin
                w_a_nxt[i] = r_mem[5'(i * 3 + d)];
                w_b_nxt[i] = r_mem[5'(9 + d * 3 + i)];
            end
        end
        w_fv_nxt     = (w_state_nxt == S_FEED);
        w_loaded_nxt = (w_state_nxt == S_FULL);
        w_busy_nxt   = (w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN);
        w_done_nxt   = (w_state_nxt == S_DONE);
    end

    // Output registers: all stream and status outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_fv     <= 1'b0;
            r_loaded <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_a[i] <= w_a_nxt[i];
                r_b[i] <= w_b_nxt[i];
            end
            r_fv     <= w_fv_nxt;
            r_loaded <= w_loaded_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Sticky overrun: any byte offered outside LOAD is lost, including one that collides with go.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (rx_valid && (r_state != S_LOAD)) begin
            r_overrun <= 1'b1;
        end
    end

    // Matrix storage: written only in LOAD, kept across reset and after DONE.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem[r_cnt] <= rx_data;
        end
    end

    assign A0         = r_a[0];
    assign A1         = r_a[1];
    assign A2         = r_a[2];
    assign B0         = r_b[0];
    assign B1         = r_b[1];
    assign B2         = r_b[2];
    assign feed_valid = r_fv;
    assign loaded     = r_loaded;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder: cycle model of load/feed/drain/done plus literal feed tables.
// Latency: the model predicts every output each cycle from the go-acceptance edge.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_matrix_feeder;

    localparam int DW    = 8;
    localparam int DRAIN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          go = 1'b0;
    logic [DW-1:0] A0, A1, A2, B0, B1, B2;
    logic          feed_valid, loaded, busy, done, overrun;

    matrix_feeder #(.DATAWIDTH(DW), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .go(go),
        .A0(A0), .A1(A1), .A2(A2), .B0(B0), .B1(B1), .B2(B2),
        .feed_valid(feed_valid), .loaded(loaded), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    int            cyc = 0;      // index of the current cycle; edge cyc ends it
    int            go_edge = -1; // edge at which go was accepted, -1 when no run is active
    int            nbytes = 0;   // bytes held (18 = both matrices complete)
    logic [DW-1:0] mmem [0:17];
    bit            m_ovr = 1'b0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        int  rb;
        bit  busy_b, full_b;
        if (rst) begin
            go_edge = -1;
            nbytes  = 0;
            m_ovr   = 1'b0;
            chk_en  = 1'b1;
        end else begin
            busy_b = (go_edge >= 0);
            rb     = cyc - go_edge;
            full_b = !busy_b && (nbytes == 18);
            if (full_b && go) begin
                go_edge = cyc;
                if (rx_valid) m_ovr = 1'b1;
            end else if (rx_valid) begin
                if (!busy_b && nbytes < 18) begin
                    mmem[5'(nbytes)] = rx_data;
                    nbytes++;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (busy_b && rb == 6 + DRAIN) begin
                go_edge = -1;
                nbytes  = 0;
            end
        end
        cyc++;
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        int r, t, d;
        bit fv;
        logic [DW-1:0] ea [0:2];
        logic [DW-1:0] eb [0:2];
        if (chk_en) begin
            r  = cyc - go_edge;
            fv = (go_edge >= 0) && (r >= 1) && (r <= 5);
            t  = r - 1;
            for (int i = 0; i < 3; i++) begin
                ea[i] = '0;
                eb[i] = '0;
                d = t - i;
                if (fv && d >= 0 && d <= 2) begin
                    ea[i] = mmem[5'(i * 3 + d)];
                    eb[i] = mmem[5'(9 + d * 3 + i)];
                end
            end
            chk("A0", 32'(A0), 32'(ea[0]));
            chk("A1", 32'(A1), 32'(ea[1]));
            chk("A2", 32'(A2), 32'(ea[2]));
            chk("B0", 32'(B0), 32'(eb[0]));
            chk("B1", 32'(B1), 32'(eb[1]));
            chk("B2", 32'(B2), 32'(eb[2]));
            chk("feed_valid", 32'(feed_valid), 32'(fv));
            chk("busy", 32'(busy), 32'((go_edge >= 0) && (r >= 1) && (r <= 5 + DRAIN)));
            chk("done", 32'(done), 32'((go_edge >= 0) && (r == 6 + DRAIN)));
            chk("loaded", 32'(loaded), 32'((go_edge < 0) && (nbytes == 18)));
            chk("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    // ---------------- stimulus ----------------
    // {A0,A1,A2} and {B0,B1,B2} for A=1..9, B=identity, t=0..4.
    logic [23:0] lit_a [0:4] = '{24'h010000, 24'h020400, 24'h030507, 24'h000608, 24'h000009};
    logic [23:0] lit_b [0:4] = '{24'h010000, 24'h000000, 24'h000100, 24'h000000, 24'h000001};

    task automatic send(input logic [DW-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic load_std();
        for (int i = 0; i < 9; i++) send(DW'(i + 1));
        for (int i = 0; i < 9; i++) send((i % 4 == 0) ? DW'(1) : DW'(0));
    endtask

    // Called in the t=0 cycle; returns in the t=4 cycle.
    task automatic check_feed_lit();
        for (int t = 0; t < 5; t++) begin
            chk("lit_A", 32'({A0, A1, A2}), 32'(lit_a[t]));
            chk("lit_B", 32'({B0, B1, B2}), 32'(lit_b[t]));
            chk("lit_feed_valid", 32'(feed_valid), 32'd1);
            if (t < 4) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_within_bound", 32'(seen), 32'd1);
    endtask

    task automatic window(input bit trap, output int nfv, output int nd);
        nfv = 0;
        nd  = 0;
        for (int i = 0; i < 40; i++) begin
            rx_data  = 8'hAA;
            rx_valid = trap && (i == 3);
            @(negedge clk);
            nfv += int'(feed_valid);
            nd  += int'(done);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        int nfv, nd;
        idle(2);
        rst = 1'b0;
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Basic feed: A=1..9, B=identity; done exactly at k+10.
        load_std();
        chk("full_loaded", 32'(loaded), 32'd1);
        pulse_go();
        check_feed_lit();
        idle(1);
        chk("drain_fv", 32'(feed_valid), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        idle(3);
        chk("k9_done", 32'(done), 32'd0);
        idle(1);
        chk("k10_done", 32'(done), 32'd1);
        chk("k10_busy", 32'(busy), 32'd0);
        idle(1);

        // Partial load ignores go; byte 18 completes; new values fed; overrun stays 0.
        for (int i = 0; i < 17; i++) send(DW'(20 + i));
        pulse_go();
        idle(2);
        chk("partial_loaded", 32'(loaded), 32'd0);
        chk("partial_fv", 32'(feed_valid), 32'd0);
        send(8'd99);
        chk("byte18_loaded", 32'(loaded), 32'd1);
        pulse_go();
        chk("new_A0_t0", 32'(A0), 32'd20);
        chk("new_B0_t0", 32'(B0), 32'd29);
        wait_done();
        idle(1);
        chk("no_overrun", 32'(overrun), 32'd0);

        // Byte together with go in FULL: go wins, byte dropped.
        load_std();
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        go       = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        go       = 1'b0;
        chk("collide_overrun", 32'(overrun), 32'd1);
        check_feed_lit();
        wait_done();
        idle(1);

        // Reset in the middle of a feed, then reload and feed again.
        load_std();
        pulse_go();
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_fv", 32'(feed_valid), 32'd0);
        chk("midrst_A", 32'({A0, A1, A2}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        load_std();
        pulse_go();
        check_feed_lit();
        wait_done();
        idle(1);

        // go held high: one feed per completed load; a byte during the feed is dropped.
        go = 1'b1;
        load_std();
        window(1'b1, nfv, nd);
        chk("hold1_feeds", 32'(nfv), 32'd5);
        chk("hold1_dones", 32'(nd), 32'd1);
        load_std();
        window(1'b0, nfv, nd);
        chk("hold2_feeds", 32'(nfv), 32'd5);
        chk("hold2_dones", 32'(nd), 32'd1);
        go = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
